// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU codes, NOP word, immediate formats.
package riscy_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LUI    = 7'b0110111;

  localparam logic [5:0] ALU_ADD  = 6'o00;
  localparam logic [5:0] ALU_JAL  = 6'o37;
  localparam logic [5:0] ALU_JALR = 6'o77;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Formats that read rs2: R, STORE, BRANCH.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == R_TYPE) || (opcode == STORE) || (opcode == BRANCH);
  endfunction

  // Formats that read rs1: everything except JAL, AUIPC, LUI (and unknown opcodes).
  function automatic logic uses_rs1(input logic [6:0] opcode);
    return (opcode == R_TYPE) || (opcode == I_TYPE) || (opcode == LOAD) ||
           (opcode == STORE)  || (opcode == BRANCH) || (opcode == JALR);
  endfunction

endpackage

// File: rtl/decode_stage_ctrl.sv
// Pure combinational RV32I control table: instruction word -> control fields and imm32.
module decode_ctrl
  import riscy_pkg::*;
(
  input  logic [31:0] instruction,
  output logic        wEn,
  output logic        mem_wEn,
  output logic        wb_sel,
  output logic        branch_op,
  output logic        op_B_sel,
  output logic [1:0]  op_A_sel,
  output logic [5:0]  ALU_Control,
  output logic [31:0] imm32,
  output logic        is_load,
  output logic        is_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic [4:0] rd;
  imm_fmt_e   fmt;

  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign funct7_5 = instruction[30];
  assign rd       = instruction[11:7];

  // Control table lookup; rd=x0 suppresses register writeback for every opcode.
  always_comb begin
    wEn         = 1'b0;
    mem_wEn     = 1'b0;
    wb_sel      = 1'b0;
    branch_op   = 1'b0;
    op_B_sel    = 1'b0;
    op_A_sel    = 2'd0;
    ALU_Control = ALU_ADD;
    fmt         = IMM_I;
    is_load     = 1'b0;
    is_illegal  = 1'b0;
    case (opcode)
      R_TYPE: begin
        ALU_Control = {2'b00, funct7_5, funct3};
        op_B_sel    = 1'b1;
        wEn         = 1'b1;
      end
      I_TYPE: begin
        ALU_Control = {2'b00, (funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
        wEn         = 1'b1;
      end
      LOAD: begin
        ALU_Control = {3'b000, funct3};
        wEn         = 1'b1;
        wb_sel      = 1'b1;
        is_load     = 1'b1;
      end
      STORE: begin
        ALU_Control = {3'b000, funct3};
        fmt         = IMM_S;
        mem_wEn     = 1'b1;
      end
      BRANCH: begin
        ALU_Control = {3'b010, funct3};
        op_B_sel    = 1'b1;
        fmt         = IMM_B;
        branch_op   = 1'b1;
      end
      JAL: begin
        ALU_Control = ALU_JAL;
        op_A_sel    = 2'd2;
        fmt         = IMM_J;
        branch_op   = 1'b1;
        wEn         = 1'b1;
      end
      JALR: begin
        ALU_Control = ALU_JALR;
        op_A_sel    = 2'd2;
        branch_op   = 1'b1;
        wEn         = 1'b1;
      end
      AUIPC: begin
        op_A_sel = 2'd1;
        op_B_sel = 1'b1;
        fmt      = IMM_U;
        wEn      = 1'b1;
      end
      LUI: begin
        op_B_sel = 1'b1;
        fmt      = IMM_U;
        wEn      = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
    if (rd == 5'd0) wEn = 1'b0;
  end

  // Sign-extended immediate assembly for the selected format.
  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
      IMM_S: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      IMM_B: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
      IMM_U: imm32 = {instruction[31:12], 12'h000};
      IMM_J: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
      default: imm32 = {{20{instruction[31]}}, instruction[31:20]};
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: ID register with valid/ready handshake, load-use scoreboard,
// load-count limit, branch flush and registered redirect to fetch.
module decode_stage
  import riscy_pkg::*;
#(
  parameter int ADDRESS_BITS = 16,
  parameter int MAX_LOADS    = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRESS_BITS-1:0] in_PC,
  input  logic [31:0]             in_instruction,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_BITS-1:0] out_PC,
  output logic [4:0]              read_sel1,
  output logic [4:0]              read_sel2,
  output logic [4:0]              write_sel,
  output logic                    wEn,
  output logic                    mem_wEn,
  output logic                    wb_sel,
  output logic                    branch_op,
  output logic                    op_B_sel,
  output logic [1:0]              op_A_sel,
  output logic [5:0]              ALU_Control,
  output logic [31:0]             imm32,
  input  logic                    ld_done,
  input  logic [4:0]              ld_rd,
  input  logic                    branch,
  input  logic [ADDRESS_BITS-1:0] branch_target,
  output logic                    next_PC_select,
  output logic [ADDRESS_BITS-1:0] target_PC,
  output logic                    illegal
);

  localparam int CW = $clog2(MAX_LOADS + 1);

  logic                    id_valid;
  logic [31:0]             id_instr;
  logic [ADDRESS_BITS-1:0] id_pc;
  logic [31:0]             sb;
  logic [31:0]             sb_eff;
  logic [31:0]             sb_clr_mask;
  logic [31:0]             sb_set_mask;
  logic [CW-1:0]           ld_count;
  logic                    ld_retire;
  logic                    is_load;
  logic                    is_illegal;
  logic                    rs1_hazard;
  logic                    rs2_hazard;
  logic                    load_full;
  logic                    stall;
  logic                    in_fire;
  logic                    out_fire;

  decode_ctrl u_ctrl (
    .instruction (id_instr),
    .wEn         (wEn),
    .mem_wEn     (mem_wEn),
    .wb_sel      (wb_sel),
    .branch_op   (branch_op),
    .op_B_sel    (op_B_sel),
    .op_A_sel    (op_A_sel),
    .ALU_Control (ALU_Control),
    .imm32       (imm32),
    .is_load     (is_load),
    .is_illegal  (is_illegal)
  );

  assign read_sel1 = id_instr[19:15];
  assign read_sel2 = id_instr[24:20];
  assign write_sel = id_instr[11:7];
  assign out_PC    = id_pc;

  // A retiring load clears its scoreboard bit in the same cycle so a dependent
  // instruction waiting in ID can issue immediately (bypass clear).
  always_comb begin
    ld_retire   = ld_done && (ld_count != '0);
    sb_clr_mask = ld_retire ? (32'd1 << ld_rd) : '0;
    sb_eff      = sb & ~sb_clr_mask;
    rs1_hazard  = uses_rs1(id_instr[6:0]) && (read_sel1 != 5'd0) && sb_eff[read_sel1];
    rs2_hazard  = uses_rs2(id_instr[6:0]) && (read_sel2 != 5'd0) && sb_eff[read_sel2];
    load_full   = is_load && (ld_count == CW'(MAX_LOADS)) && !ld_retire;
    stall       = rs1_hazard || rs2_hazard || load_full;
  end

  // Handshake: a taken branch flushes ID and blocks both issue and acceptance.
  always_comb begin
    out_valid   = id_valid && !stall && !branch;
    out_fire    = out_valid && out_ready;
    in_ready    = !branch && (!id_valid || out_fire);
    in_fire     = in_valid && in_ready;
    sb_set_mask = (out_fire && is_load && (write_sel != 5'd0)) ? (32'd1 << write_sel) : '0;
  end

  // ID register; instruction/PC only change on acceptance so out_* hold while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      id_valid <= 1'b0;
      id_instr <= NOP_WORD;
      id_pc    <= '0;
    end else begin
      if (in_fire) begin
        id_instr <= in_instruction;
        id_pc    <= in_PC;
      end
      if (branch)        id_valid <= 1'b0;
      else if (in_fire)  id_valid <= 1'b1;
      else if (out_fire) id_valid <= 1'b0;
    end
  end

  // Scoreboard and in-flight load count; a branch does not cancel issued loads.
  always_ff @(posedge clock) begin
    if (reset) begin
      sb       <= '0;
      ld_count <= '0;
    end else begin
      sb <= sb_eff | sb_set_mask;
      case ({out_fire && is_load, ld_retire})
        2'b10:   ld_count <= ld_count + CW'(1);
        2'b01:   ld_count <= ld_count - CW'(1);
        default: ld_count <= ld_count;
      endcase
    end
  end

  // Redirect request pulse to fetch, and sticky illegal-opcode flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      next_PC_select <= 1'b0;
      target_PC      <= '0;
      illegal        <= 1'b0;
    end else begin
      next_PC_select <= branch;
      if (branch) target_PC <= branch_target;
      if (out_fire && is_illegal) illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  localparam int AB = 16;

  localparam logic [31:0] I_ADDI1 = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADD2  = 32'h0010_8133; // add  x2,x1,x1
  localparam logic [31:0] I_LW3   = 32'h0000_2183; // lw   x3,0(x0)
  localparam logic [31:0] I_LW5   = 32'h0000_2283; // lw   x5,0(x0)
  localparam logic [31:0] I_LW6   = 32'h0000_2303; // lw   x6,0(x0)
  localparam logic [31:0] I_ADD4  = 32'h0031_8233; // add  x4,x3,x3
  localparam logic [31:0] I_SW    = 32'hFE51_2C23; // sw   x5,-8(x2)
  localparam logic [31:0] I_JAL0  = 32'h0080_006F; // jal  x0,+8
  localparam logic [31:0] I_JAL1  = 32'hFFDF_F0EF; // jal  x1,-4
  localparam logic [31:0] I_BAD   = 32'h0000_007F;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AB-1:0] in_PC;
  logic [31:0]   in_instruction;
  logic          out_valid;
  logic          out_ready;
  logic [AB-1:0] out_PC;
  logic [4:0]    read_sel1, read_sel2, write_sel;
  logic          wEn, mem_wEn, wb_sel, branch_op, op_B_sel;
  logic [1:0]    op_A_sel;
  logic [5:0]    ALU_Control;
  logic [31:0]   imm32;
  logic          ld_done;
  logic [4:0]    ld_rd;
  logic          branch;
  logic [AB-1:0] branch_target;
  logic          next_PC_select;
  logic [AB-1:0] target_PC;
  logic          illegal;

  int checks   = 0;
  int failures = 0;

  decode_stage #(.ADDRESS_BITS(AB), .MAX_LOADS(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_PC          (in_PC),
    .in_instruction (in_instruction),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_PC         (out_PC),
    .read_sel1      (read_sel1),
    .read_sel2      (read_sel2),
    .write_sel      (write_sel),
    .wEn            (wEn),
    .mem_wEn        (mem_wEn),
    .wb_sel         (wb_sel),
    .branch_op      (branch_op),
    .op_B_sel       (op_B_sel),
    .op_A_sel       (op_A_sel),
    .ALU_Control    (ALU_Control),
    .imm32          (imm32),
    .ld_done        (ld_done),
    .ld_rd          (ld_rd),
    .branch         (branch),
    .branch_target  (branch_target),
    .next_PC_select (next_PC_select),
    .target_PC      (target_PC),
    .illegal        (illegal)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Outputs are compared at the falling edge, after inputs have settled.
  task automatic mid();
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [AB-1:0] pc);
    in_valid       = v;
    in_instruction = ins;
    in_PC          = pc;
  endtask

  initial begin
    reset = 1'b1; drive(1'b0, '0, '0); out_ready = 1'b1;
    ld_done = 1'b0; ld_rd = '0; branch = 1'b0; branch_target = '0;
    step(); step();
    reset = 1'b0;
    mid();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_imm32", imm32, 32'd0);
    check("rst_alu", 32'(ALU_Control), 32'd0);
    check("rst_wEn", 32'(wEn), 32'd0);
    check("rst_out_PC", 32'(out_PC), 32'd0);
    check("rst_npc_sel", 32'(next_PC_select), 32'd0);
    check("rst_target", 32'(target_PC), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);

    // 1: back-to-back ADDI / ADD stream
    step(); drive(1'b1, I_ADDI1, 16'h0010);
    step(); drive(1'b1, I_ADD2, 16'h0014);
    mid();
    check("t1_addi_valid", 32'(out_valid), 32'd1);
    check("t1_addi_imm", imm32, 32'd5);
    check("t1_addi_alu", 32'(ALU_Control), 32'd0);
    check("t1_addi_rd", 32'(write_sel), 32'd1);
    check("t1_addi_wEn", 32'(wEn), 32'd1);
    check("t1_addi_pc", 32'(out_PC), 32'h10);
    check("t1_in_ready0", 32'(in_ready), 32'd1);
    step(); drive(1'b0, '0, '0);
    mid();
    check("t1_add_valid", 32'(out_valid), 32'd1);
    check("t1_add_alu", 32'(ALU_Control), 32'd0);
    check("t1_add_rs", {22'd0, read_sel1, read_sel2}, {22'd0, 5'd1, 5'd1});
    check("t1_add_bsel", 32'(op_B_sel), 32'd1);
    check("t1_add_pc", 32'(out_PC), 32'h14);
    check("t1_in_ready1", 32'(in_ready), 32'd1);
    step(); mid();
    check("t1_empty", 32'(out_valid), 32'd0);

    // 2: load-use stall released by same-cycle ld_done
    drive(1'b1, I_LW3, 16'h0020);
    step(); drive(1'b1, I_ADD4, 16'h0024);
    mid();
    check("t2_lw_valid", 32'(out_valid), 32'd1);
    check("t2_lw_wbsel", 32'(wb_sel), 32'd1);
    check("t2_lw_alu", 32'(ALU_Control), 32'd2);
    step(); drive(1'b0, '0, '0);
    mid();
    check("t2_stall_valid", 32'(out_valid), 32'd0);
    check("t2_stall_ready", 32'(in_ready), 32'd0);
    step(); mid();
    check("t2_stall2_valid", 32'(out_valid), 32'd0);
    ld_done = 1'b1; ld_rd = 5'd3;
    #1;
    check("t2_bypass_valid", 32'(out_valid), 32'd1);
    check("t2_bypass_pc", 32'(out_PC), 32'h24);
    step(); ld_done = 1'b0; ld_rd = '0;
    mid();
    check("t2_after_valid", 32'(out_valid), 32'd0);
    check("t2_after_ready", 32'(in_ready), 32'd1);

    // 3: SW held by out_ready=0, then issues once
    drive(1'b1, I_SW, 16'h0030); out_ready = 1'b0;
    step(); drive(1'b1, I_ADDI1, 16'h0034);
    for (int i = 0; i < 3; i++) begin
      mid();
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_ready", 32'(in_ready), 32'd0);
      check("t3_hold_memw", 32'(mem_wEn), 32'd1);
      check("t3_hold_wEn", 32'(wEn), 32'd0);
      check("t3_hold_imm", imm32, 32'hFFFF_FFF8);
      check("t3_hold_pc", 32'(out_PC), 32'h30);
      step();
    end
    out_ready = 1'b1;
    mid();
    check("t3_rel_ready", 32'(in_ready), 32'd1);
    step(); drive(1'b0, '0, '0);
    mid();
    check("t3_next_pc", 32'(out_PC), 32'h34);
    check("t3_next_memw", 32'(mem_wEn), 32'd0);
    step();

    // 4: branch flushes ID and produces a one-cycle redirect
    drive(1'b1, I_ADD2, 16'h0040); out_ready = 1'b0;
    step(); drive(1'b0, '0, '0);
    branch = 1'b1; branch_target = 16'h0040; out_ready = 1'b1;
    mid();
    check("t4_br_valid", 32'(out_valid), 32'd0);
    check("t4_br_npc", 32'(next_PC_select), 32'd0);
    step(); branch = 1'b0; branch_target = '0;
    mid();
    check("t4_npc_sel", 32'(next_PC_select), 32'd1);
    check("t4_target", 32'(target_PC), 32'h40);
    check("t4_flushed", 32'(out_valid), 32'd0);
    step(); mid();
    check("t4_npc_pulse", 32'(next_PC_select), 32'd0);
    check("t4_flushed2", 32'(out_valid), 32'd0);

    // 6: JAL with rd=x0 and rd=x1
    drive(1'b1, I_JAL0, 16'h0050);
    step(); drive(1'b1, I_JAL1, 16'h0054);
    mid();
    check("t6_jal0_wEn", 32'(wEn), 32'd0);
    check("t6_jal0_imm", imm32, 32'd8);
    check("t6_jal0_bop", 32'(branch_op), 32'd1);
    check("t6_jal0_asel", 32'(op_A_sel), 32'd2);
    check("t6_jal0_alu", 32'(ALU_Control), 32'o37);
    step(); drive(1'b0, '0, '0);
    mid();
    check("t6_jal1_wEn", 32'(wEn), 32'd1);
    check("t6_jal1_imm", imm32, 32'hFFFF_FFFC);
    check("t6_jal1_rd", 32'(write_sel), 32'd1);
    step();

    // 5: illegal opcode is sticky; reset clears it and the scoreboard
    drive(1'b1, I_BAD, 16'h0060);
    step(); drive(1'b0, '0, '0);
    mid();
    check("t5_bad_valid", 32'(out_valid), 32'd1);
    check("t5_bad_wEn", 32'(wEn), 32'd0);
    check("t5_illegal_pre", 32'(illegal), 32'd0);
    step(); mid();
    check("t5_illegal_set", 32'(illegal), 32'd1);
    step(); step(); mid();
    check("t5_illegal_sticky", 32'(illegal), 32'd1);
    drive(1'b1, I_LW3, 16'h0070);
    step(); drive(1'b0, '0, '0);
    step();
    reset = 1'b1;
    step(); reset = 1'b0;
    mid();
    check("t5_rst_illegal", 32'(illegal), 32'd0);
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_pc", 32'(out_PC), 32'd0);
    check("t5_rst_imm", imm32, 32'd0);
    check("t5_rst_target", 32'(target_PC), 32'd0);
    drive(1'b1, I_ADD4, 16'h0080);
    step(); drive(1'b0, '0, '0);
    mid();
    check("t5_sb_clear", 32'(out_valid), 32'd1);
    step();

    // Load count saturation at MAX_LOADS=2
    drive(1'b1, I_LW3, 16'h0090);
    step(); drive(1'b1, I_LW5, 16'h0094);
    step(); drive(1'b1, I_LW6, 16'h0098);
    step(); drive(1'b0, '0, '0);
    mid();
    check("sat_stall", 32'(out_valid), 32'd0);
    check("sat_pc", 32'(out_PC), 32'h98);
    ld_done = 1'b1; ld_rd = 5'd5;
    #1;
    check("sat_release", 32'(out_valid), 32'd1);
    step(); ld_done = 1'b0; ld_rd = '0;
    mid();
    check("sat_empty", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
